// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph constants and helpers for the 7-segment scan driver
package seg7_pkg;

    // Segment bit positions within {g,f,e,d,c,b,a}
    localparam int unsigned SEG_IDX_A = 0;
    localparam int unsigned SEG_IDX_B = 1;
    localparam int unsigned SEG_IDX_C = 2;
    localparam int unsigned SEG_IDX_D = 3;
    localparam int unsigned SEG_IDX_E = 4;
    localparam int unsigned SEG_IDX_F = 5;
    localparam int unsigned SEG_IDX_G = 6;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Never returns less than 1 so single-digit builds still get a legal vector
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// rtl/seg7_glyph.sv - 4-bit code to active-high glyph; SEG7_HEX_EN enables A-F glyphs
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = SEG_BLANK;
        case (code_i)
            4'd0:  glyph_o = SEG_0;
            4'd1:  glyph_o = SEG_1;
            4'd2:  glyph_o = SEG_2;
            4'd3:  glyph_o = SEG_3;
            4'd4:  glyph_o = SEG_4;
            4'd5:  glyph_o = SEG_5;
            4'd6:  glyph_o = SEG_6;
            4'd7:  glyph_o = SEG_7;
            4'd8:  glyph_o = SEG_8;
            4'd9:  glyph_o = SEG_9;
`ifdef SEG7_HEX_EN
            4'd10: glyph_o = SEG_A;
            4'd11: glyph_o = SEG_B;
            4'd12: glyph_o = SEG_C;
            4'd13: glyph_o = SEG_D;
            4'd14: glyph_o = SEG_E;
            4'd15: glyph_o = SEG_F;
`else
            default: glyph_o = SEG_BLANK;
`endif
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment scan driver with frame-coherent update; SEG7_HEX_EN selects hex glyphs
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   num,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg7,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int IDX_W = clog2(DIGITS);
    localparam int CNT_W = clog2(SCAN_DIV);
    localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_ACTIVE_LOW}};

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_num_q, shadow_num_d, active_num_q, active_num_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
    logic                pending_q, pending_d;
    logic [6:0]          seg7_q;
    logic                dp_q;
    logic [DIGITS-1:0]   dig_sel_q;
    logic                frame_done_q;

    logic                wrap, boundary, run_zero;
    logic [DIGITS-1:0]   lz_blank, sel_onehot;
    logic [3:0]          cur_code;
    logic [6:0]          glyph_raw, seg_on;

    assign wrap     = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign boundary = wrap && (idx_q == IDX_W'(DIGITS - 1));

    always_comb begin
        cnt_d        = wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shadow_num_d = shadow_num_q;
        shadow_dp_d  = shadow_dp_q;
        active_num_d = active_num_q;
        active_dp_d  = active_dp_q;
        pending_d    = pending_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        if (load) begin
            shadow_num_d = num;
            shadow_dp_d  = dp_in;
            pending_d    = 1'b1;
        end
        // Display content only swaps at a frame boundary; a coincident load bypasses the shadow
        if (boundary) begin
            if (load) begin
                active_num_d = num;
                active_dp_d  = dp_in;
                pending_d    = 1'b0;
            end else if (pending_q) begin
                active_num_d = shadow_num_q;
                active_dp_d  = shadow_dp_q;
                pending_d    = 1'b0;
            end
        end
    end

    // A digit is blanked when it and every digit above it are zero; digit 0 never blanks
    always_comb begin
        lz_blank = '0;
        run_zero = blank_lz;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run_zero    = run_zero && (active_num_q[4*k +: 4] == 4'd0);
            lz_blank[k] = run_zero;
        end
    end

    always_comb begin
        sel_onehot = '0;
        for (int k = 0; k < DIGITS; k++) begin
            sel_onehot[k] = (idx_q == IDX_W'(k));
        end
    end

    assign cur_code = active_num_q[{idx_q, 2'b00} +: 4];
    assign seg_on   = lz_blank[idx_q] ? SEG_BLANK : glyph_raw;

    seg7_glyph u_glyph (
        .code_i  (cur_code),
        .glyph_o (glyph_raw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_num_q <= '0;
            shadow_dp_q  <= '0;
            active_num_q <= '0;
            active_dp_q  <= '0;
            pending_q    <= 1'b0;
            seg7_q       <= SEG_OFF;
            dp_q         <= SEG_ACTIVE_LOW;
            dig_sel_q    <= SEL_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_num_q <= shadow_num_d;
            shadow_dp_q  <= shadow_dp_d;
            active_num_q <= active_num_d;
            active_dp_q  <= active_dp_d;
            pending_q    <= pending_d;
            seg7_q       <= seg_on ^ SEG_OFF;
            dp_q         <= active_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
            dig_sel_q    <= (cnt_q == '0) ? SEL_OFF : (sel_onehot ^ SEL_OFF);
            frame_done_q <= boundary;
        end
    end

    assign seg7       = seg7_q;
    assign dp         = dp_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;

endmodule
